// File: rtl/controle_drenagem_pkg.sv
// Shared types for the garage drainage-pump controller.
package drenagem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_ON,
        STAGGER,
        BOTH_ON,
        FAULT
    } estado_t;

    localparam logic LEAD_A = 1'b0;
    localparam logic LEAD_B = 1'b1;

endpackage

// File: rtl/controle_drenagem_if.sv
// Sensor/command bundle between the flood monitor side and the pump controller.
interface controle_drenagem_if;
    logic alerta;
    logic emergencia;
    logic vazio;
    logic falha_a;
    logic falha_b;
    logic bomba_a;
    logic bomba_b;
    logic fecha_portao;
    logic alarme_falha;
    logic lead;

    modport master (
        output alerta, emergencia, vazio, falha_a, falha_b,
        input  bomba_a, bomba_b, fecha_portao, alarme_falha, lead
    );

    modport slave (
        input  alerta, emergencia, vazio, falha_a, falha_b,
        output bomba_a, bomba_b, fecha_portao, alarme_falha, lead
    );
endinterface

// File: rtl/controle_drenagem_filtro.sv
// Level debounce: q follows d only after DEBOUNCE_CYC consecutive differing samples.
module filtro_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/controle_drenagem.sv
// Lead/lag drainage-pump sequencer with trip handling and gate-close request.
// Optional DRENO_ALTERNANCIA_EN: swap lead pump on every normal return to IDLE.
module controle_drenagem
    import drenagem_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int MIN_ON_CYC   = 16,
    parameter int MAX_ON_CYC   = 1024,
    parameter int STAGGER_CYC  = 8
) (
    input  logic clk,
    input  logic reset,
    controle_drenagem_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ON_CYC + 1);

    logic alerta_f, emergencia_f, vazio_f;

    filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro_alerta (
        .clk(clk), .reset(reset), .d(bus.alerta), .q(alerta_f)
    );
    filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro_emergencia (
        .clk(clk), .reset(reset), .d(bus.emergencia), .q(emergencia_f)
    );
    filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro_vazio (
        .clk(clk), .reset(reset), .d(bus.vazio), .q(vazio_f)
    );

    estado_t          estado, estado_nxt;
    logic             lead_r, lead_nxt, alterna;
    logic             trip_a, trip_b, trip_a_nxt, trip_b_nxt;
    logic [CNT_W-1:0] on_cnt, on_cnt_nxt, stg_cnt, stg_cnt_nxt;
    logic             bomba_a_r, bomba_b_r, fecha_r, alarme_r;
    logic             bomba_a_nxt, bomba_b_nxt, fecha_nxt, alarme_nxt;

    always_comb begin
        trip_a_nxt  = trip_a | bus.falha_a;
        trip_b_nxt  = trip_b | bus.falha_b;
        estado_nxt  = estado;
        on_cnt_nxt  = on_cnt;
        stg_cnt_nxt = stg_cnt;
        alterna     = 1'b0;

        if (trip_a_nxt && trip_b_nxt) begin
            estado_nxt = FAULT;
        end else begin
            case (estado)
                IDLE: begin
                    if (emergencia_f)  estado_nxt = STAGGER;
                    else if (alerta_f) estado_nxt = LEAD_ON;
                end
                LEAD_ON: begin
                    if (emergencia_f || on_cnt == CNT_W'(MAX_ON_CYC - 1)) begin
                        estado_nxt = STAGGER;
                    end else if (vazio_f && on_cnt >= CNT_W'(MIN_ON_CYC)) begin
                        estado_nxt = IDLE;
                        alterna    = 1'b1;
                    end else if (on_cnt != '1) begin
                        on_cnt_nxt = on_cnt + 1'b1;
                    end
                end
                STAGGER: begin
                    if (stg_cnt == CNT_W'(STAGGER_CYC - 1)) estado_nxt  = BOTH_ON;
                    else                                    stg_cnt_nxt = stg_cnt + 1'b1;
                end
                BOTH_ON: begin
                    if (!emergencia_f) begin
                        if (vazio_f) begin
                            estado_nxt = IDLE;
                            alterna    = 1'b1;
                        end else begin
                            estado_nxt = LEAD_ON;
                        end
                    end
                end
                FAULT:   estado_nxt = FAULT;
                default: estado_nxt = IDLE;
            endcase
        end

        if (estado_nxt != estado) begin
            on_cnt_nxt  = '0;
            stg_cnt_nxt = '0;
        end

        // A single trip pins lead to the healthy pump; a double trip freezes it.
`ifdef DRENO_ALTERNANCIA_EN
        lead_nxt = lead_r ^ alterna;
`else
        lead_nxt = LEAD_A;
`endif
        if (trip_a_nxt && trip_b_nxt) lead_nxt = lead_r;
        else if (trip_a_nxt)          lead_nxt = LEAD_B;
        else if (trip_b_nxt)          lead_nxt = LEAD_A;

        bomba_a_nxt = 1'b0;
        bomba_b_nxt = 1'b0;
        case (estado_nxt)
            LEAD_ON, STAGGER: begin
                bomba_a_nxt = (lead_nxt == LEAD_A);
                bomba_b_nxt = (lead_nxt == LEAD_B);
            end
            BOTH_ON: begin
                bomba_a_nxt = 1'b1;
                bomba_b_nxt = 1'b1;
            end
            default: ;
        endcase
        bomba_a_nxt = bomba_a_nxt & ~trip_a_nxt;
        bomba_b_nxt = bomba_b_nxt & ~trip_b_nxt;

        alarme_nxt = (estado_nxt == FAULT);
        fecha_nxt  = (estado_nxt == FAULT)
                   || (((estado_nxt == STAGGER) || (estado_nxt == BOTH_ON)) && emergencia_f)
                   || ((trip_a_nxt || trip_b_nxt) && (estado_nxt != IDLE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            lead_r    <= LEAD_A;
            trip_a    <= 1'b0;
            trip_b    <= 1'b0;
            on_cnt    <= '0;
            stg_cnt   <= '0;
            bomba_a_r <= 1'b0;
            bomba_b_r <= 1'b0;
            fecha_r   <= 1'b0;
            alarme_r  <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            lead_r    <= lead_nxt;
            trip_a    <= trip_a_nxt;
            trip_b    <= trip_b_nxt;
            on_cnt    <= on_cnt_nxt;
            stg_cnt   <= stg_cnt_nxt;
            bomba_a_r <= bomba_a_nxt;
            bomba_b_r <= bomba_b_nxt;
            fecha_r   <= fecha_nxt;
            alarme_r  <= alarme_nxt;
        end
    end

    assign bus.bomba_a      = bomba_a_r;
    assign bus.bomba_b      = bomba_b_r;
    assign bus.fecha_portao = fecha_r;
    assign bus.alarme_falha = alarme_r;
    assign bus.lead         = lead_r;
endmodule

// File: tb/tb_controle_drenagem.sv
// Bench for controle_drenagem: directed scenarios plus randomized run against a level model.
module tb_controle_drenagem;
    localparam int DEB = 4;
    localparam int MIN = 16;
    localparam int MAX = 32;
    localparam int STG = 8;
`ifdef DRENO_ALTERNANCIA_EN
    localparam bit EXP_TOG = 1'b1;
`else
    localparam bit EXP_TOG = 1'b0;
`endif

    localparam int M_IDLE = 0, M_LEAD = 1, M_WAIT = 2, M_BOTH = 3, M_FAULT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    controle_drenagem_if bus();

    controle_drenagem #(
        .DEBOUNCE_CYC(DEB), .MIN_ON_CYC(MIN), .MAX_ON_CYC(MAX), .STAGGER_CYC(STG)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Level model: filtered levels tracked as run lengths, pump demand as a mode.
    bit m_f[3];
    bit m_last[3];
    int m_run[3];
    bit m_ta, m_tb, m_lead;
    int m_mode, m_ontime, m_wait;
    bit e_a, e_b, e_fecha, e_alarme;

    task automatic model_step(input bit rst, input bit al, input bit em, input bit va,
                              input bit fa, input bit fb);
        bit raw[3];
        bit ta, tb, tog;
        int mode;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_f[i] = 0; m_last[i] = 0; m_run[i] = 0;
            end
            m_ta = 0; m_tb = 0; m_lead = 0; m_mode = M_IDLE; m_ontime = 0; m_wait = 0;
            e_a = 0; e_b = 0; e_fecha = 0; e_alarme = 0;
            return;
        end
        ta = m_ta | fa;
        tb = m_tb | fb;
        tog = 0;
        mode = m_mode;
        if (ta && tb) mode = M_FAULT;
        else if (m_mode == M_IDLE) begin
            if (m_f[1]) begin mode = M_WAIT; m_wait = STG; end
            else if (m_f[0]) begin mode = M_LEAD; m_ontime = 0; end
        end else if (m_mode == M_LEAD) begin
            if (m_f[1] || m_ontime == MAX - 1) begin mode = M_WAIT; m_wait = STG; end
            else if (m_f[2] && m_ontime >= MIN) begin mode = M_IDLE; tog = 1; end
            else m_ontime++;
        end else if (m_mode == M_WAIT) begin
            if (m_wait == 1) mode = M_BOTH;
            else m_wait--;
        end else if (m_mode == M_BOTH) begin
            if (!m_f[1]) begin
                if (m_f[2]) begin mode = M_IDLE; tog = 1; end
                else begin mode = M_LEAD; m_ontime = 0; end
            end
        end

        if (ta && tb) m_lead = m_lead;
        else if (ta) m_lead = 1;
        else if (tb) m_lead = 0;
        else m_lead = EXP_TOG ? (m_lead ^ tog) : 1'b0;

        e_a = !ta && (mode == M_BOTH || ((mode == M_LEAD || mode == M_WAIT) && !m_lead));
        e_b = !tb && (mode == M_BOTH || ((mode == M_LEAD || mode == M_WAIT) && m_lead));
        e_alarme = (mode == M_FAULT);
        e_fecha = (mode == M_FAULT) || ((mode == M_WAIT || mode == M_BOTH) && m_f[1])
                || ((ta || tb) && mode != M_IDLE);

        raw[0] = al; raw[1] = em; raw[2] = va;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] == m_last[i] && m_run[i] > 0) m_run[i]++;
            else begin m_last[i] = raw[i]; m_run[i] = 1; end
            if (m_run[i] >= DEB && m_last[i] != m_f[i]) m_f[i] = m_last[i];
        end
        m_ta = ta; m_tb = tb; m_mode = mode;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.alerta = 0; bus.emergencia = 0; bus.vazio = 0; bus.falha_a = 0; bus.falha_b = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus.alerta = 1; bus.emergencia = 1; bus.vazio = 1; bus.falha_a = 1; bus.falha_b = 1;
        reset = 1;
        repeat (6) tick();
        got = {bus.bomba_a, bus.bomba_b, bus.fecha_portao, bus.alarme_falha, bus.lead};
        checks++;
        if (got !== 5'b00000) begin
            errors++; $display("FAIL reset_outputs got %b exp 00000", got);
        end
        idle_inputs();
        reset = 0;
        repeat (6) tick();
        got = {bus.bomba_a, bus.bomba_b, bus.fecha_portao, bus.alarme_falha, bus.lead};
        checks++;
        if (got !== 5'b00000) begin
            errors++; $display("FAIL post_reset_idle got %b exp 00000", got);
        end
    endtask

    task automatic test_lead_cycle();
        do_reset();
        bus.alerta = 1;
        repeat (4) tick();
        checks++;
        if (bus.bomba_a !== 1'b0) begin errors++; $display("FAIL lead_early bomba_a=%b exp 0", bus.bomba_a); end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b} !== 2'b10) begin
            errors++; $display("FAIL lead_start pumps=%b exp 10", {bus.bomba_a, bus.bomba_b});
        end
        repeat (15) tick();
        bus.alerta = 0;
        repeat (10) tick();
        bus.vazio = 1;
        repeat (4) tick();
        checks++;
        if (bus.bomba_a !== 1'b1) begin errors++; $display("FAIL vazio_early bomba_a=%b exp 1", bus.bomba_a); end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b, bus.lead} !== {2'b00, EXP_TOG}) begin
            errors++; $display("FAIL vazio_stop pumps_lead=%b exp %b", {bus.bomba_a, bus.bomba_b, bus.lead}, {2'b00, EXP_TOG});
        end
        bus.vazio = 0;
    endtask

    task automatic test_chatter();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.alerta = ((i / 2) % 2 == 0);
            tick();
            checks++;
            if ({bus.bomba_a, bus.bomba_b} !== 2'b00) begin
                errors++; $display("FAIL chatter cyc %0d pumps=%b exp 00", i, {bus.bomba_a, bus.bomba_b});
            end
        end
        bus.alerta = 0;
    endtask

    task automatic test_emergencia();
        do_reset();
        bus.emergencia = 1;
        repeat (4) tick();
        checks++;
        if (bus.bomba_a !== 1'b0) begin errors++; $display("FAIL emerg_early bomba_a=%b exp 0", bus.bomba_a); end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b, bus.fecha_portao} !== 3'b101) begin
            errors++; $display("FAIL emerg_lead got %b exp 101", {bus.bomba_a, bus.bomba_b, bus.fecha_portao});
        end
        repeat (7) tick();
        checks++;
        if (bus.bomba_b !== 1'b0) begin errors++; $display("FAIL stagger_early bomba_b=%b exp 0", bus.bomba_b); end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b, bus.fecha_portao} !== 3'b111) begin
            errors++; $display("FAIL stagger_lag got %b exp 111", {bus.bomba_a, bus.bomba_b, bus.fecha_portao});
        end
        bus.emergencia = 0;
        repeat (4) tick();
        checks++;
        if ({bus.bomba_b, bus.fecha_portao} !== 2'b11) begin
            errors++; $display("FAIL emerg_fall_early got %b exp 11", {bus.bomba_b, bus.fecha_portao});
        end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b, bus.fecha_portao} !== 3'b100) begin
            errors++; $display("FAIL emerg_fall got %b exp 100", {bus.bomba_a, bus.bomba_b, bus.fecha_portao});
        end
    endtask

    task automatic test_escalation();
        do_reset();
        bus.alerta = 1;
        repeat (5) tick();
        repeat (39) tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b} !== 2'b10) begin
            errors++; $display("FAIL escal_early pumps=%b exp 10", {bus.bomba_a, bus.bomba_b});
        end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b, bus.fecha_portao} !== 3'b110) begin
            errors++; $display("FAIL escal_lag got %b exp 110", {bus.bomba_a, bus.bomba_b, bus.fecha_portao});
        end
        tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b} !== 2'b10) begin
            errors++; $display("FAIL escal_back pumps=%b exp 10", {bus.bomba_a, bus.bomba_b});
        end
        bus.alerta = 0;
    endtask

    task automatic test_trip();
        logic [4:0] got;
        do_reset();
        bus.alerta = 1;
        repeat (8) tick();
        bus.falha_a = 1;
        tick();
        bus.falha_a = 0;
        got = {bus.bomba_a, bus.bomba_b, bus.lead, bus.fecha_portao, bus.alarme_falha};
        checks++;
        if (got !== 5'b01110) begin errors++; $display("FAIL trip_a got %b exp 01110", got); end
        repeat (3) tick();
        got = {bus.bomba_a, bus.bomba_b, bus.lead, bus.fecha_portao, bus.alarme_falha};
        checks++;
        if (got !== 5'b01110) begin errors++; $display("FAIL trip_a_latched got %b exp 01110", got); end
        bus.falha_b = 1;
        tick();
        bus.falha_b = 0;
        bus.emergencia = 1; bus.vazio = 1; bus.alerta = 0;
        for (int i = 0; i < 10; i++) begin
            got = {bus.bomba_a, bus.bomba_b, bus.lead, bus.fecha_portao, bus.alarme_falha};
            checks++;
            if (got !== 5'b00111) begin errors++; $display("FAIL fault_hold cyc %0d got %b exp 00111", i, got); end
            tick();
        end
        reset = 1;
        tick();
        reset = 0;
        idle_inputs();
        got = {bus.bomba_a, bus.bomba_b, bus.lead, bus.fecha_portao, bus.alarme_falha};
        checks++;
        if (got !== 5'b00000) begin errors++; $display("FAIL fault_reset got %b exp 00000", got); end
    endtask

    task automatic test_reset_mid_run();
        logic [4:0] got;
        do_reset();
        bus.emergencia = 1;
        repeat (13) tick();
        checks++;
        if ({bus.bomba_a, bus.bomba_b} !== 2'b11) begin
            errors++; $display("FAIL both_on pumps=%b exp 11", {bus.bomba_a, bus.bomba_b});
        end
        reset = 1;
        tick();
        got = {bus.bomba_a, bus.bomba_b, bus.fecha_portao, bus.alarme_falha, bus.lead};
        checks++;
        if (got !== 5'b00000) begin errors++; $display("FAIL reset_mid_run got %b exp 00000", got); end
        reset = 0;
        bus.emergencia = 0;
    endtask

    task automatic test_random();
        bit al, em, va, fa, fb, rst;
        logic [4:0] got, exp;
        al = 0; em = 0; va = 0;
        idle_inputs();
        reset = 1;
        @(posedge clk);
        model_step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(11) == 0) al = ~al;
            if ($urandom_range(19) == 0) em = ~em;
            if ($urandom_range(11) == 0) va = ~va;
            fa  = ($urandom_range(799) == 0);
            fb  = ($urandom_range(799) == 0);
            rst = ($urandom_range(499) == 0);
            bus.alerta = al; bus.emergencia = em; bus.vazio = va;
            bus.falha_a = fa; bus.falha_b = fb;
            reset = rst;
            @(posedge clk);
            model_step(rst, al, em, va, fa, fb);
            @(negedge clk);
            got = {bus.bomba_a, bus.bomba_b, bus.fecha_portao, bus.alarme_falha, bus.lead};
            exp = {e_a, e_b, e_fecha, e_alarme, m_lead};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random cyc %0d got %b exp %b", n, got, exp);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_lead_cycle();
        test_chatter();
        test_emergencia();
        test_escalation();
        test_trip();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
